// File: rtl/bp_nonsynth_multi_resp_checker.sv
// Simulation-side response checker: per-channel actual/expected FIFOs drained in
// order after an LFSR-randomised delay, with sticky mismatch, timeout and done status.
module bp_nonsynth_multi_resp_checker #(
  parameter int          channels_p  = 1,
  parameter int          width_p     = 32,
  parameter int          els_p       = 16,
  parameter int          min_delay_p = 0,
  parameter int          max_delay_p = 15,
  parameter int          timeout_p   = 4096,
  parameter logic [31:0] seed_p      = 32'h1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [channels_p-1:0]         act_v_i,
  input  logic [channels_p*width_p-1:0] act_data_i,
  output logic [channels_p-1:0]         act_ready_o,
  input  logic [channels_p-1:0]         exp_v_i,
  input  logic [channels_p*width_p-1:0] exp_data_i,
  output logic [channels_p-1:0]         exp_ready_o,
  input  logic                          stream_done_i,
  output logic                          done_o,
  output logic                          error_o,
  output logic                          timeout_o,
  output logic [15:0]                   err_count_o,
  output logic [2:0]                    first_err_chan_o,
  output logic [width_p-1:0]            first_err_act_o,
  output logic [width_p-1:0]            first_err_exp_o
);

  localparam int AW    = $clog2(els_p);
  localparam int RANGE = max_delay_p - min_delay_p + 1;
  localparam int DW    = (max_delay_p > 0) ? $clog2(max_delay_p + 1) : 1;
  localparam int SW    = $clog2(timeout_p + 1);

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [DW-1:0] dly_load(input logic [31:0] s);
    return DW'(32'(min_delay_p) + (s % 32'(RANGE)));
  endfunction

  logic                 init_q;
  logic [AW:0]          act_wp_q [channels_p];
  logic [AW:0]          act_rp_q [channels_p];
  logic [AW:0]          exp_wp_q [channels_p];
  logic [AW:0]          exp_rp_q [channels_p];
  logic [width_p-1:0]   act_mem_q [channels_p][els_p];
  logic [width_p-1:0]   exp_mem_q [channels_p][els_p];
  logic [31:0]          lfsr_q [channels_p];
  logic [DW-1:0]        dly_q [channels_p];
  logic [SW-1:0]        stall_q;
  logic                 sd_q;

  logic [channels_p-1:0] act_empty, exp_empty, act_full, exp_full;
  logic [channels_p-1:0] act_push, exp_push, cmp, mis;
  logic [width_p-1:0]    act_head [channels_p];
  logic [width_p-1:0]    exp_head [channels_p];
  logic                  any_cmp, all_empty;
  logic [3:0]            nmis;
  logic [16:0]           err_sum;
  logic [SW-1:0]         stall_d;
  logic [2:0]            fe_chan;
  logic [width_p-1:0]    fe_act, fe_exp;

  always_comb begin
    act_empty = '0;
    exp_empty = '0;
    act_full  = '0;
    exp_full  = '0;
    act_push  = '0;
    exp_push  = '0;
    cmp       = '0;
    mis       = '0;
    nmis      = '0;
    fe_chan   = '0;
    fe_act    = '0;
    fe_exp    = '0;
    for (int c = 0; c < channels_p; c++) begin
      act_empty[c] = (act_wp_q[c] == act_rp_q[c]);
      exp_empty[c] = (exp_wp_q[c] == exp_rp_q[c]);
      act_full[c]  = (act_wp_q[c][AW] != act_rp_q[c][AW]) &&
                     (act_wp_q[c][AW-1:0] == act_rp_q[c][AW-1:0]);
      exp_full[c]  = (exp_wp_q[c][AW] != exp_rp_q[c][AW]) &&
                     (exp_wp_q[c][AW-1:0] == exp_rp_q[c][AW-1:0]);
      act_head[c]  = act_mem_q[c][act_rp_q[c][AW-1:0]];
      exp_head[c]  = exp_mem_q[c][exp_rp_q[c][AW-1:0]];
      // Readiness is judged on the pre-pop occupancy, so a full FIFO never bypasses.
      act_ready_o[c] = init_q && !act_full[c];
      exp_ready_o[c] = init_q && !exp_full[c];
      act_push[c]  = act_v_i[c] && act_ready_o[c];
      exp_push[c]  = exp_v_i[c] && exp_ready_o[c];
      cmp[c]       = init_q && !act_empty[c] && !exp_empty[c] && (dly_q[c] == '0);
      mis[c]       = cmp[c] && (act_head[c] != exp_head[c]);
      nmis         = nmis + 4'(mis[c]);
    end
    for (int c = channels_p - 1; c >= 0; c--) begin
      if (mis[c]) begin
        fe_chan = 3'(c);
        fe_act  = act_head[c];
        fe_exp  = exp_head[c];
      end
    end
    any_cmp   = |cmp;
    all_empty = (&act_empty) && (&exp_empty);
    err_sum   = {1'b0, err_count_o} + 17'(nmis);
    if (any_cmp || all_empty)
      stall_d = '0;
    else if (stall_q == SW'(timeout_p))
      stall_d = stall_q;
    else
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < channels_p; c++) begin
      if (act_push[c]) act_mem_q[c][act_wp_q[c][AW-1:0]] <= act_data_i[c*width_p +: width_p];
      if (exp_push[c]) exp_mem_q[c][exp_wp_q[c][AW-1:0]] <= exp_data_i[c*width_p +: width_p];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      init_q           <= 1'b0;
      stall_q          <= '0;
      sd_q             <= 1'b0;
      done_o           <= 1'b0;
      error_o          <= 1'b0;
      timeout_o        <= 1'b0;
      err_count_o      <= '0;
      first_err_chan_o <= '0;
      first_err_act_o  <= '0;
      first_err_exp_o  <= '0;
      for (int c = 0; c < channels_p; c++) begin
        act_wp_q[c] <= '0;
        act_rp_q[c] <= '0;
        exp_wp_q[c] <= '0;
        exp_rp_q[c] <= '0;
        lfsr_q[c]   <= seed_p ^ 32'(c);
        dly_q[c]    <= '0;
      end
    end else begin
      init_q <= 1'b1;
      for (int c = 0; c < channels_p; c++) begin
        if (act_push[c]) act_wp_q[c] <= act_wp_q[c] + 1'b1;
        if (exp_push[c]) exp_wp_q[c] <= exp_wp_q[c] + 1'b1;
        if (cmp[c]) begin
          act_rp_q[c] <= act_rp_q[c] + 1'b1;
          exp_rp_q[c] <= exp_rp_q[c] + 1'b1;
          lfsr_q[c]   <= lfsr_next(lfsr_q[c]);
        end
        // Delay reloads on the first active edge and after every compare.
        if (!init_q || cmp[c])
          dly_q[c] <= dly_load(lfsr_q[c]);
        else if (dly_q[c] != '0)
          dly_q[c] <= dly_q[c] - 1'b1;
      end
      stall_q <= stall_d;
      if (stall_d == SW'(timeout_p)) timeout_o <= 1'b1;
      sd_q <= sd_q | stream_done_i;
      if (sd_q && all_empty) done_o <= 1'b1;
      if (|mis) begin
        error_o     <= 1'b1;
        err_count_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (!error_o) begin
          first_err_chan_o <= fe_chan;
          first_err_act_o  <= fe_act;
          first_err_exp_o  <= fe_exp;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_nonsynth_multi_resp_checker.sv
// Directed and randomised checks of the response checker using two parameter sets.
module tb_bp_nonsynth_multi_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: 2 channels, 4-deep FIFOs, zero delay, short timeout
  logic        a_rst, a_sd, a_done, a_err, a_to;
  logic [1:0]  a_act_v, a_act_rdy, a_exp_v, a_exp_rdy;
  logic [63:0] a_act_d, a_exp_d;
  logic [15:0] a_cnt;
  logic [2:0]  a_fch;
  logic [31:0] a_fact, a_fexp;

  bp_nonsynth_multi_resp_checker #(
    .channels_p(2), .width_p(32), .els_p(4), .min_delay_p(0), .max_delay_p(0),
    .timeout_p(10), .seed_p(32'h1)
  ) dut_a (
    .clk_i(clk), .reset_i(a_rst),
    .act_v_i(a_act_v), .act_data_i(a_act_d), .act_ready_o(a_act_rdy),
    .exp_v_i(a_exp_v), .exp_data_i(a_exp_d), .exp_ready_o(a_exp_rdy),
    .stream_done_i(a_sd), .done_o(a_done), .error_o(a_err), .timeout_o(a_to),
    .err_count_o(a_cnt), .first_err_chan_o(a_fch),
    .first_err_act_o(a_fact), .first_err_exp_o(a_fexp)
  );

  // Instance B: 3 channels, 8-deep FIFOs, random delay 3..7
  logic        b_rst, b_sd, b_done, b_err, b_to;
  logic [2:0]  b_act_v, b_act_rdy, b_exp_v, b_exp_rdy;
  logic [95:0] b_act_d, b_exp_d;
  logic [15:0] b_cnt;
  logic [2:0]  b_fch;
  logic [31:0] b_fact, b_fexp;

  bp_nonsynth_multi_resp_checker #(
    .channels_p(3), .width_p(32), .els_p(8), .min_delay_p(3), .max_delay_p(7),
    .timeout_p(4096), .seed_p(32'h1234_5678)
  ) dut_b (
    .clk_i(clk), .reset_i(b_rst),
    .act_v_i(b_act_v), .act_data_i(b_act_d), .act_ready_o(b_act_rdy),
    .exp_v_i(b_exp_v), .exp_data_i(b_exp_d), .exp_ready_o(b_exp_rdy),
    .stream_done_i(b_sd), .done_o(b_done), .error_o(b_err), .timeout_o(b_to),
    .err_count_o(b_cnt), .first_err_chan_o(b_fch),
    .first_err_act_o(b_fact), .first_err_exp_o(b_fexp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_a();
    a_rst = 1'b0; a_sd = 1'b0;
    a_act_v = '0; a_exp_v = '0; a_act_d = '0; a_exp_d = '0;
    step(); step();
    a_rst = 1'b1;
    step();
  endtask

  task automatic reset_b();
    b_rst = 1'b0; b_sd = 1'b0;
    b_act_v = '0; b_exp_v = '0; b_act_d = '0; b_exp_d = '0;
    step(); step();
    b_rst = 1'b1;
    step();
  endtask

  // Random-test reference data
  logic [31:0] r_act [3][30];
  logic [31:0] r_exp [3][30];

  initial begin
    int last, ngaps, bad, nmis_m, first_idx;
    int sent;
    bit full_seen;
    int ai [3];
    int ei [3];
    logic [31:0] v;

    a_rst = 1'b0; b_rst = 1'b0; a_sd = 1'b0; b_sd = 1'b0;
    a_act_v = '0; a_exp_v = '0; a_act_d = '0; a_exp_d = '0;
    b_act_v = '0; b_exp_v = '0; b_act_d = '0; b_exp_d = '0;
    step();
    chk("rst_ready", {28'h0, a_act_rdy, a_exp_rdy}, 32'h0);
    chk("rst_status", {29'h0, a_done, a_err, a_to}, 32'h0);
    chk("rst_count", {16'h0, a_cnt}, 32'h0);

    // Two in-order matching compares, then done
    reset_a();
    chk("ready_after_release", {30'h0, a_act_rdy}, 32'h3);
    a_exp_v = 2'b01; a_exp_d = 64'hA; step();
    a_exp_d = 64'hB; step();
    a_exp_v = '0;
    a_act_v = 2'b01; a_act_d = 64'hA; step();
    a_act_d = 64'hB; step();
    a_act_v = '0; a_sd = 1'b1;
    step();
    chk("match_done_early", {31'h0, a_done}, 32'h0);
    step();
    chk("match_done", {31'h0, a_done}, 32'h1);
    chk("match_cnt", {16'h0, a_cnt}, 32'h0);
    chk("match_err", {31'h0, a_err}, 32'h0);

    // Simultaneous mismatches on both channels: lowest channel recorded
    reset_a();
    a_exp_v = 2'b11; a_exp_d = {32'h5, 32'h3};
    a_act_v = 2'b11; a_act_d = {32'h6, 32'h4};
    step();
    a_exp_v = '0; a_act_v = '0;
    chk("mis_err_pre", {31'h0, a_err}, 32'h0);
    step();
    chk("mis_cnt", {16'h0, a_cnt}, 32'h2);
    chk("mis_err", {31'h0, a_err}, 32'h1);
    chk("mis_chan", {29'h0, a_fch}, 32'h0);
    chk("mis_act", a_fact, 32'h4);
    chk("mis_exp", a_fexp, 32'h3);

    // Async reset with residue and sticky error, then clean traffic
    a_act_v = 2'b01;
    for (int i = 1; i <= 3; i++) begin a_act_d = 64'(i); step(); end
    a_act_v = '0;
    #1 a_rst = 1'b0;
    #1;
    chk("async_status", {29'h0, a_done, a_err, a_to}, 32'h0);
    chk("async_cnt", {16'h0, a_cnt}, 32'h0);
    chk("async_first", {29'h0, a_fch} | a_fact | a_fexp, 32'h0);
    chk("async_ready", {28'h0, a_act_rdy, a_exp_rdy}, 32'h0);
    @(negedge clk);
    a_rst = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      a_act_v = 2'b11; a_exp_v = 2'b11;
      a_act_d = {32'(100 + i), 32'(200 + i)}; a_exp_d = a_act_d;
      step();
    end
    a_act_v = '0; a_exp_v = '0;
    step(); step();
    chk("post_rst_cnt", {16'h0, a_cnt}, 32'h0);
    chk("post_rst_err", {31'h0, a_err}, 32'h0);

    // Full act FIFO, one exp entry frees one slot
    reset_a();
    a_act_v = 2'b01;
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", {31'h0, a_act_rdy[0]}, 32'h1);
      a_act_d = 64'(32'h70 + i);
      step();
    end
    a_act_v = '0;
    chk("full_ready", {31'h0, a_act_rdy[0]}, 32'h0);
    a_exp_v = 2'b01; a_exp_d = 64'h70; step();
    a_exp_v = '0;
    chk("cmp_cycle_ready", {31'h0, a_act_rdy[0]}, 32'h0);
    step();
    chk("freed_ready", {31'h0, a_act_rdy[0]}, 32'h1);
    chk("freed_cnt", {16'h0, a_cnt}, 32'h0);

    // Timeout on an unmatched entry; done blocked by residue
    reset_a();
    a_act_v = 2'b01; a_act_d = 64'h99; step();
    a_act_v = '0; a_sd = 1'b1;
    repeat (9) step();
    chk("timeout_pre", {31'h0, a_to}, 32'h0);
    step();
    chk("timeout", {31'h0, a_to}, 32'h1);
    repeat (3) step();
    chk("timeout_no_done", {31'h0, a_done}, 32'h0);
    chk("timeout_no_err", {31'h0, a_err}, 32'h0);

    // 200 matching entries with random delays 3..7 between compares
    reset_b();
    sent = 0; full_seen = 0; last = -1; ngaps = 0;
    for (int t = 0; t < 6000 && sent < 200; t++) begin
      if (!b_act_rdy[0]) full_seen = 1;
      else if (full_seen) begin
        if (last >= 0) begin
          chk("gap_range", 32'((t - last - 1) >= 3 && (t - last - 1) <= 7), 32'h1);
          ngaps++;
        end
        last = t;
      end
      if (b_act_rdy[0] && b_exp_rdy[0]) begin
        v = $urandom;
        b_act_v = 3'b001; b_exp_v = 3'b001;
        b_act_d = {64'h0, v}; b_exp_d = {64'h0, v};
        sent++;
      end else begin
        b_act_v = '0; b_exp_v = '0;
      end
      step();
    end
    b_act_v = '0; b_exp_v = '0; b_sd = 1'b1;
    chk("gap_count", 32'(ngaps > 150), 32'h1);
    for (int t = 0; t < 500 && !b_done; t++) step();
    chk("stream_done", {31'h0, b_done}, 32'h1);
    chk("stream_err", {31'h0, b_err}, 32'h0);
    chk("stream_to", {31'h0, b_to}, 32'h0);

    // Randomised multi-channel traffic against a reference model
    reset_b();
    bad = $urandom_range(0, 2);
    nmis_m = 0; first_idx = -1;
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 30; i++) begin
        r_act[c][i] = $urandom;
        r_exp[c][i] = r_act[c][i];
        if (c == bad && ($urandom_range(0, 3) == 0 || (i == 29 && nmis_m == 0))) begin
          r_exp[c][i] = r_act[c][i] ^ 32'($urandom_range(1, 255));
          nmis_m++;
          if (first_idx < 0) first_idx = i;
        end
      end
    for (int c = 0; c < 3; c++) begin ai[c] = 0; ei[c] = 0; end
    for (int t = 0; t < 8000 && (ai[0] + ai[1] + ai[2] + ei[0] + ei[1] + ei[2]) < 180; t++) begin
      for (int c = 0; c < 3; c++) begin
        b_act_v[c] = (ai[c] < 30) && ($urandom_range(0, 1) == 1);
        b_exp_v[c] = (ei[c] < 30) && ($urandom_range(0, 1) == 1);
        b_act_d[c*32 +: 32] = r_act[c][(ai[c] < 30) ? ai[c] : 0];
        b_exp_d[c*32 +: 32] = r_exp[c][(ei[c] < 30) ? ei[c] : 0];
        if (b_act_v[c] && b_act_rdy[c]) ai[c]++;
        if (b_exp_v[c] && b_exp_rdy[c]) ei[c]++;
      end
      step();
    end
    b_act_v = '0; b_exp_v = '0; b_sd = 1'b1;
    chk("rand_all_sent", 32'(ai[0] + ai[1] + ai[2] + ei[0] + ei[1] + ei[2]), 32'd180);
    for (int t = 0; t < 1000 && !b_done; t++) step();
    chk("rand_done", {31'h0, b_done}, 32'h1);
    chk("rand_cnt", {16'h0, b_cnt}, 32'(nmis_m));
    chk("rand_err", {31'h0, b_err}, 32'h1);
    chk("rand_chan", {29'h0, b_fch}, 32'(bad));
    chk("rand_act", b_fact, r_act[bad][first_idx]);
    chk("rand_exp", b_fexp, r_exp[bad][first_idx]);
    chk("rand_to", {31'h0, b_to}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_nonsynth_multi_resp_checker.md
BP_NONSYNTH_MULTI_RESP_CHECKER -- requirements
Module: bp_nonsynth_multi_resp_checker

Interface
REQ-001 SHALL have parameter channels_p, default 1, number of independent response channels (1..8).
REQ-002 SHALL have parameter width_p, default 32, data width per channel.
REQ-003 SHALL have parameter els_p, default 16, depth of each actual and expected FIFO (power of 2, >=2).
REQ-004 SHALL have parameters min_delay_p, default 0, and max_delay_p, default 15, bounds of the random pop delay in cycles.
REQ-005 SHALL have parameter timeout_p, default 4096, number of stall cycles before a timeout is flagged.
REQ-006 SHALL have parameter seed_p, default 32'h1, nonzero LFSR seed; channel c uses seed_p ^ c.
REQ-007 SHALL have port clk_i, input, 1, clock; all state updates on its rising edge.
REQ-008 SHALL have port reset_i, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have ports act_v_i / act_data_i / act_ready_o, input/input/output, channels_p / channels_p*width_p / channels_p, DUT responses with valid-ready per channel.
REQ-010 SHALL have ports exp_v_i / exp_data_i / exp_ready_o, input/input/output, channels_p / channels_p*width_p / channels_p, expected values with valid-ready per channel.
REQ-011 SHALL have port stream_done_i, input, 1, stimulus source has issued its last expected entry.
REQ-012 SHALL have ports done_o, error_o, timeout_o, output, 1 each, sticky status.
REQ-013 SHALL have ports err_count_o, output, 16, saturating mismatch count; first_err_chan_o, output, 3, channel of first mismatch; first_err_act_o / first_err_exp_o, output, width_p each, data of first mismatch.

Function
REQ-014 Each channel SHALL hold one actual FIFO and one expected FIFO, each els_p deep; a write occurs when v_i and ready_o are both 1.
REQ-015 act_ready_o[c] / exp_ready_o[c] SHALL be 1 exactly when the corresponding FIFO is not full; a FIFO SHALL accept a write in the same cycle it is popped from full only if not full before the pop (no bypass).
REQ-016 Each channel SHALL hold a delay counter; it SHALL load min_delay_p + (lfsr mod (max_delay_p-min_delay_p+1)) after every compare and at reset release, and decrement by 1 per cycle while nonzero.
REQ-017 Each channel SHALL use an independent 32-bit Galois LFSR (taps 32,22,2,1), advancing one step on every compare.
REQ-018 A compare on channel c SHALL occur in a cycle where both FIFOs of c are non-empty and its delay counter is 0; both heads SHALL pop in that cycle.
REQ-019 On a compare with unequal heads: error_o SHALL set the following cycle; err_count_o SHALL increment, saturating at 16'hFFFF.
REQ-020 first_err_* SHALL capture only the first mismatch after reset; on simultaneous first mismatches the lowest channel index SHALL win.
REQ-021 Compare result SHALL be registered: status outputs reflect a compare one cycle later.
REQ-022 A stall counter SHALL increment each cycle any FIFO is non-empty and no compare occurs, and clear on any compare or when all FIFOs are empty; on reaching timeout_p, timeout_o SHALL set and the counter SHALL hold.
REQ-023 stream_done_i SHALL be latched sticky; done_o SHALL set one cycle after the latch is set and all 2*channels_p FIFOs are empty.
REQ-024 An actual entry arriving while the expected FIFO is empty SHALL wait (not an error); only timeout flags an unmatched residue.
REQ-025 error_o, timeout_o, done_o SHALL remain set until reset; compares SHALL continue after error.
REQ-026 Channels SHALL be fully independent; ordering is checked only within a channel.

Reset
REQ-027 While reset_i is 0: all FIFOs empty, all ready_o 0, delay counters 0, LFSRs at their seeds, stall counter 0, all status outputs and err_count_o/first_err_* 0.
REQ-028 Reset assertion mid-compare SHALL discard all in-flight state immediately; no compare SHALL be counted in the cycle reset_i rises.
REQ-029 First delay load SHALL occur on the first rising edge with reset_i 1.

Verification
REQ-030 channels_p=1, min=max=0: push exp 0xA,0xB then act 0xA,0xB -> two compares on consecutive cycles, err_count_o=0, error_o=0; stream_done_i then done_o=1.
REQ-031 channels_p=2: ch1 exp 0x5 act 0x6, ch0 exp 0x3 act 0x4 same cycle -> err_count_o=2, first_err_chan_o=0, first_err_act_o=0x4, first_err_exp_o=0x3.
REQ-032 els_p=4: push 4 act entries, no exp -> act_ready_o=0 after 4th; push 1 exp -> one compare, act_ready_o=1 next cycle.
REQ-033 timeout_p=10: one act entry, never an exp -> timeout_o=1 exactly 10 cycles after the entry lands; done_o stays 0 despite stream_done_i.
REQ-034 min=3,max=7, 200 matching entries -> every inter-compare gap within 3..7 cycles, error_o=0, done_o=1.
REQ-035 Drive reset_i to 0 with 3 entries queued and error_o=1 -> all outputs 0 asynchronously; after release, matching traffic yields err_count_o=0.
